// File: rtl/calendar_pkg.sv
// Shared month/length-code constants and FSM state type for the calendar controller.
package calendar_pkg;

  localparam logic [3:0] JAN = 4'd0;
  localparam logic [3:0] FEB = 4'd1;
  localparam logic [3:0] MAR = 4'd2;
  localparam logic [3:0] APR = 4'd3;
  localparam logic [3:0] MAY = 4'd4;
  localparam logic [3:0] JUN = 4'd5;
  localparam logic [3:0] JUL = 4'd6;
  localparam logic [3:0] AUG = 4'd7;
  localparam logic [3:0] SEP = 4'd8;
  localparam logic [3:0] OCT = 4'd9;
  localparam logic [3:0] NOV = 4'd10;
  localparam logic [3:0] DEC = 4'd11;

  localparam logic [2:0] LEN_INV = 3'd0;
  localparam logic [2:0] LEN_28  = 3'd1;
  localparam logic [2:0] LEN_29  = 3'd2;
  localparam logic [2:0] LEN_30  = 3'd3;
  localparam logic [2:0] LEN_31  = 3'd4;

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  // Invalid codes map to length 0 so no day value can be accepted against them.
  function automatic logic [4:0] code_len(input logic [2:0] code);
    case (code)
      LEN_28:  code_len = 5'd28;
      LEN_29:  code_len = 5'd29;
      LEN_30:  code_len = 5'd30;
      LEN_31:  code_len = 5'd31;
      default: code_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/calendar_ctrl_month_days.sv
// Month-to-length-code decode; leap selects the February length.
module month_days
  import calendar_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [2:0] days
);

  always_comb begin
    days = LEN_INV;
    case (month)
      APR, JUN, SEP, NOV:                days = LEN_30;
      FEB:                               days = leap ? LEN_29 : LEN_28;
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = LEN_31;
      default:                           days = LEN_INV;
    endcase
  end

endmodule

// File: rtl/calendar_ctrl.sv
// Tick-driven day/month calendar with STOP/RUN control, date load and rollover pulses.
module calendar_ctrl
  import calendar_pkg::*;
#(
  parameter int unsigned TICKS_PER_DAY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] load_month,
  input  logic [4:0] load_day,
  input  logic       leap,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [2:0] days,
  output logic       running,
  output logic       month_end,
  output logic       year_end,
  output logic       load_err
);

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_DAY - 1);

  state_t     state, state_nxt;
  logic [7:0] tick_cnt;
  logic [2:0] load_code;
  logic [4:0] cur_len, load_len;
  logic       load_ok, tick, day_adv, wrap;

  month_days u_cur_days  (.month(month),      .leap(leap), .days(days));
  month_days u_load_days (.month(load_month), .leap(leap), .days(load_code));

  // Any load (legal or not) freezes counting for that cycle.
  always_comb begin
    cur_len  = code_len(days);
    load_len = code_len(load_code);
    load_ok  = (load_month <= DEC) && (load_day != 5'd0) && (load_day <= load_len);
    tick     = (state == RUN) && enable && !load;
    day_adv  = tick && (tick_cnt == TICK_LAST);
    wrap     = (day >= cur_len);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop)           state_nxt = STOP;
      default:                     state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= STOP;
    else        state <= state_nxt;
  end

  assign running = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      month     <= JAN;
      day       <= 5'd1;
      tick_cnt  <= 8'd0;
      month_end <= 1'b0;
      year_end  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      month_end <= 1'b0;
      year_end  <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          month    <= load_month;
          day      <= load_day;
          tick_cnt <= 8'd0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        if (day_adv) begin
          tick_cnt <= 8'd0;
          if (wrap) begin
            day       <= 5'd1;
            month_end <= 1'b1;
            if (month >= DEC) begin
              month    <= JAN;
              year_end <= 1'b1;
            end else begin
              month <= month + 4'd1;
            end
          end else begin
            day <= day + 5'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 8'd1;
        end
      end
    end
  end

endmodule
